// File: rtl/seq_divider_if.sv
// Operand/result bundle for the sequential divider.
//
// Handshake: start is sampled on a rising clock edge only while the divider
// is idle (busy=0). When it is accepted there, dividend and divisor are
// latched at that same edge. busy is high for the whole run. done is a
// one-cycle pulse, and it is never high in the same cycle as busy.
// quotient, remainder and dbz are valid from the done cycle onward and hold
// until the next completion. Because the done cycle is already idle, a
// start asserted during done is accepted with no gap.
interface seq_divider_if #(parameter int N = 16);
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic           dbz;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, done, dbz, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, dbz, quotient, remainder
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider: 2N-bit dividend / N-bit divisor, resolving
// one quotient bit per clock for a fixed 2N-cycle latency. A zero divisor
// still runs the full 2N cycles. It then reports quotient = all ones,
// remainder = low half of the dividend, and raises dbz.
module seq_divider #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave bus,
  output logic         dbg_state   // 1 while in RUN
);

  localparam int CW = $clog2(2*N);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [2*N-1:0] q_reg;      // dividend shifting out, quotient shifting in
  logic [N-1:0]   d_reg;      // latched divisor
  logic [N:0]     p_reg;      // partial remainder
  logic [CW-1:0]  cnt;        // iteration index within RUN
  logic           zero_reg;   // divisor was zero
  logic [N-1:0]   lo_reg;     // low half of dividend, reported on dbz

  logic [N:0]     trial;
  logic [N:0]     p_step;
  logic [2*N-1:0] q_step;
  logic           accept;
  logic           last;

  logic           done_r;
  logic           dbz_r;
  logic [2*N-1:0] quot_r;
  logic [N-1:0]   rem_r;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: accept start in IDLE, leave RUN after the 2N-th step
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt == CW'(2*N-1)) begin
          last      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One restoring step: subtract the divisor from the shifted remainder; keep the result only if it is non-negative
  always_comb begin
    trial = {p_reg[N-1:0], q_reg[2*N-1]} - {1'b0, d_reg};
    if (!trial[N]) begin
      p_step = trial;
      q_step = {q_reg[2*N-2:0], 1'b1};
    end else begin
      p_step = {p_reg[N-1:0], q_reg[2*N-1]};
      q_step = {q_reg[2*N-2:0], 1'b0};
    end
  end

  // Working registers: load on accept, step every RUN cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg    <= '0;
      d_reg    <= '0;
      p_reg    <= '0;
      cnt      <= '0;
      zero_reg <= 1'b0;
      lo_reg   <= '0;
    end else if (accept) begin
      q_reg    <= bus.dividend;
      d_reg    <= bus.divisor;
      p_reg    <= '0;
      cnt      <= '0;
      zero_reg <= (bus.divisor == '0);
      lo_reg   <= bus.dividend[N-1:0];
    end else if (state == S_RUN) begin
      q_reg <= q_step;
      p_reg <= p_step;
      cnt   <= cnt + CW'(1);
    end
  end

  // Result registers: written on the final step and held until the next completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
    end else begin
      done_r <= 1'b0;
      if (last) begin
        done_r <= 1'b1;
        dbz_r  <= zero_reg;
        quot_r <= zero_reg ? '1 : q_step;
        rem_r  <= zero_reg ? lo_reg : p_step[N-1:0];
      end
    end
  end

  assign bus.busy      = (state == S_RUN);
  assign bus.done      = done_r;
  assign bus.dbz       = dbz_r;
  assign bus.quotient  = quot_r;
  assign bus.remainder = rem_r;
  assign dbg_state     = (state == S_RUN);

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider.
// The reference model works only from arithmetic (/ and %) and a cycle
// countdown. Directed vectors also carry hand-computed literal results.
module tb_seq_divider;

  localparam int N  = 16;
  localparam int W  = 2*N + N + 1;   // {dbz, quotient, remainder}
  localparam int LAT = 2*N;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dbg_state;

  int checks = 0;
  int errors = 0;

  seq_divider_if #(.N(N)) intf ();

  seq_divider #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (intf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  int             m_left = 0;
  logic           m_done = 1'b0;
  logic           m_dbz  = 1'b0;
  logic [2*N-1:0] m_quot = '0;
  logic [N-1:0]   m_rem  = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0;
      m_done = 1'b0;
      m_dbz  = 1'b0;
      m_quot = '0;
      m_rem  = '0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          {m_dbz, m_quot, m_rem} = e;
          m_done = 1'b1;
        end
      end else if (intf.start) begin
        logic [2*N-1:0] a;
        logic [2*N-1:0] b;
        a = intf.dividend;
        b = {{N{1'b0}}, intf.divisor};
        if (b == 0) exp_q.push_back({1'b1, {(2*N){1'b1}}, a[N-1:0]});
        else begin
          logic [2*N-1:0] qq;
          logic [2*N-1:0] rr;
          qq = a / b;
          rr = a % b;
          exp_q.push_back({1'b0, qq, rr[N-1:0]});
        end
        m_left = LAT;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("busy",      {63'd0, intf.busy}, {63'd0, (m_left > 0)});
    chk("done",      {63'd0, intf.done}, {63'd0, m_done});
    chk("busy_done_excl", {63'd0, intf.busy & intf.done}, 64'd0);
    chk("dbg_state", {63'd0, dbg_state}, {63'd0, (m_left > 0)});
    chk("quotient",  {32'd0, intf.quotient}, {32'd0, m_quot});
    chk("remainder", {48'd0, intf.remainder}, {48'd0, m_rem});
    chk("dbz",       {63'd0, intf.dbz}, {63'd0, m_dbz});
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; holds start for one cycle and returns at the next negedge.
  task automatic start_op(input logic [2*N-1:0] a, input logic [N-1:0] b);
    intf.start    = 1'b1;
    intf.dividend = a;
    intf.divisor  = b;
    @(negedge clk);
    intf.start    = 1'b0;
  endtask

  // Waits for done and checks the result against the literal values given.
  task automatic wait_done(input string name, input logic [2*N-1:0] q,
                           input logic [N-1:0] r, input logic z, input int lat);
    int n;
    n = 0;
    while (!intf.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_seen"}, {63'd0, intf.done}, 64'd1);
    if (lat > 0) chk({name, "_lat"}, n, lat);
    chk({name, "_q"},    {32'd0, intf.quotient}, {32'd0, q});
    chk({name, "_r"},    {48'd0, intf.remainder}, {48'd0, r});
    chk({name, "_dbz"},  {63'd0, intf.dbz}, {63'd0, z});
    chk({name, "_busy"}, {63'd0, intf.busy}, 64'd0);
  endtask

  task automatic count_dones(input string name, input int cycles, input int exp);
    int c;
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (intf.done) c++;
    end
    chk(name, c, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    intf.start    = 1'b0;
    intf.dividend = '0;
    intf.divisor  = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_busy", {63'd0, intf.busy}, 64'd0);
    chk("rst_done", {63'd0, intf.done}, 64'd0);
    chk("rst_dbz",  {63'd0, intf.dbz}, 64'd0);
    chk("rst_q",    {32'd0, intf.quotient}, 64'd0);
    chk("rst_r",    {48'd0, intf.remainder}, 64'd0);

    // Product inverse
    start_op(32'd298265, 16'd145);
    wait_done("t1", 32'd2057, 16'd0, 1'b0, LAT);
    @(negedge clk);

    // Back-to-back: second start issued in the done cycle
    start_op(32'd51926, 16'd25);
    wait_done("t2a", 32'd2077, 16'd1, 1'b0, LAT);
    start_op(32'hFFFFFFFF, 16'hFFFF);
    wait_done("t2b", 32'h00010001, 16'd0, 1'b0, LAT);
    @(negedge clk);

    // Extremes
    start_op(32'hFFFFFFFF, 16'd1);
    wait_done("t3a", 32'hFFFFFFFF, 16'd0, 1'b0, LAT);
    @(negedge clk);
    start_op(32'd100, 16'hFFFF);
    wait_done("t3b", 32'd0, 16'd100, 1'b0, LAT);
    @(negedge clk);

    // Divide by zero, then a valid division clears dbz
    start_op(32'h12345678, 16'd0);
    wait_done("t4a", 32'hFFFFFFFF, 16'h5678, 1'b1, LAT);
    @(negedge clk);
    chk("t4_dbz_held", {63'd0, intf.dbz}, 64'd1);
    start_op(32'd7, 16'd3);
    wait_done("t4b", 32'd2, 16'd1, 1'b0, LAT);
    @(negedge clk);

    // Start while busy is ignored
    start_op(32'd1000, 16'd7);
    repeat (4) @(negedge clk);
    start_op(32'd500, 16'd5);
    repeat (4) @(negedge clk);
    start_op(32'd500, 16'd5);
    intf.dividend = '0;
    intf.divisor  = '0;
    wait_done("t5", 32'd142, 16'd6, 1'b0, 0);
    count_dones("t5_single_done", 40, 0);

    // Asynchronous reset mid-operation
    start_op(32'd1000, 16'd7);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_busy", {63'd0, intf.busy}, 64'd0);
    chk("t6_done", {63'd0, intf.done}, 64'd0);
    chk("t6_q",    {32'd0, intf.quotient}, 64'd0);
    chk("t6_r",    {48'd0, intf.remainder}, 64'd0);
    chk("t6_dbz",  {63'd0, intf.dbz}, 64'd0);
    #3 reset = 1'b0;
    @(negedge clk);
    count_dones("t6_no_done", 40, 0);
    start_op(32'd60, 16'd7);
    wait_done("t6b", 32'd8, 16'd4, 1'b0, LAT);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
